// File: rtl/bin2bcd_display.sv
// bin2bcd_display: sequential double-dabble converter from a packed binary
// display word to 8 BCD digits, with leading-zero blank mask and overflow flag.
module bin2bcd_display #(
    parameter int unsigned IN_W    = 32,
    parameter int unsigned DIGITS  = 8,
    parameter int unsigned MAX_VAL = 99999999
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       data_in,
    input  logic                  field_mode,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank_mask,
    output logic                  ovf
);

    localparam int unsigned ACC_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_W);
    localparam int          HALF  = int'(DIGITS / 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    bin_q, bin_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fmode_q, fmode_d;
    logic               pend_ovf_q, pend_ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]  blank_q, blank_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   acc_adj_c;
    logic [DIGITS-1:0]  blank_c;

    // Add-3 correction of every BCD nibble that is 5 or more before the shift.
    always_comb begin
        acc_adj_c = acc_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj_c[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero mask; in field mode each 4-digit half is blanked on its own.
    always_comb begin : blank_gen
        logic run;
        run     = 1'b1;
        blank_c = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (fmode_q && (i == HALF - 1)) begin
                run = 1'b1;
            end
            run = run & (acc_q[4*i +: 4] == 4'd0);
            if ((i != 0) && !(fmode_q && (i == HALF))) begin
                blank_c[i] = run;
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        fmode_d    = fmode_q;
        pend_ovf_d = pend_ovf_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d      = data_in;
                    fmode_d    = field_mode;
                    pend_ovf_d = (data_in > IN_W'(MAX_VAL));
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d = {acc_adj_c[ACC_W-2:0], bin_q[IN_W-1]};
                bin_d = {bin_q[IN_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IN_W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                bcd_d   = pend_ovf_q ? '1 : acc_q;
                blank_d = pend_ovf_q ? '0 : blank_c;
                ovf_d   = pend_ovf_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            fmode_q    <= 1'b0;
            pend_ovf_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            blank_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            fmode_q    <= fmode_d;
            pend_ovf_q <= pend_ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign bcd_out    = bcd_q;
    assign blank_mask = blank_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_bin2bcd_display.sv
// Testbench for bin2bcd_display: directed corner cases plus random words
// checked against a decimal-arithmetic reference model.
module tb_bin2bcd_display;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        start;
    logic [31:0] data_in;
    logic        field_mode;
    logic        busy;
    logic        done;
    logic [31:0] bcd_out;
    logic [7:0]  blank_mask;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    bin2bcd_display dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .data_in    (data_in),
        .field_mode (field_mode),
        .busy       (busy),
        .done       (done),
        .bcd_out    (bcd_out),
        .blank_mask (blank_mask),
        .ovf        (ovf)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Compare one observed value with its expectation.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits of the value, all-F on overflow.
    function automatic logic [31:0] model_bcd(input logic [31:0] d);
        logic [31:0] r;
        int unsigned v;
        if (d > 32'd99999999) return 32'hFFFF_FFFF;
        r = '0;
        v = d;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference: digit i is blank when the field value is below 10^i (i >= 1 in its field).
    function automatic logic [7:0] model_mask(input logic [31:0] d, input logic fm);
        logic [7:0] m;
        int unsigned hi, lo, p;
        m = '0;
        if (d > 32'd99999999) return m;
        if (!fm) begin
            p = 1;
            for (int i = 1; i < 8; i++) begin
                p = p * 10;
                m[i] = (d < p);
            end
        end else begin
            hi = d / 10000;
            lo = d % 10000;
            p = 1;
            for (int i = 1; i < 4; i++) begin
                p = p * 10;
                m[4 + i] = (hi < p);
                m[i]     = (lo < p);
            end
        end
        return m;
    endfunction

    // Present a request for one edge, then scramble the inputs.
    task automatic start_conv(input logic [31:0] d, input logic fm);
        @(negedge sys_clk);
        start      = 1'b1;
        data_in    = d;
        field_mode = fm;
        @(posedge sys_clk);
        #1;
        start      = 1'b0;
        data_in    = $urandom;
        field_mode = 1'($urandom_range(0, 1));
    endtask

    // Wait for done (bounded), checking latency and busy width when first_edge is 0.
    task automatic wait_done(input string tag, input int first_edge);
        int edges;
        int busy_cnt;
        edges    = first_edge;
        busy_cnt = 0;
        while (1) begin
            if (busy) busy_cnt++;
            @(posedge sys_clk);
            #1;
            edges++;
            if (done || edges > 100) break;
        end
        check_eq({tag, "_latency"}, 32'(edges), 32'd33);
        if (first_edge == 0) check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [31:0] d, input logic fm);
        check_eq({tag, "_bcd"},  bcd_out, model_bcd(d));
        check_eq({tag, "_mask"}, 32'(blank_mask), 32'(model_mask(d, fm)));
        check_eq({tag, "_ovf"},  32'(ovf), 32'(d > 32'd99999999));
    endtask

    // Full conversion with all checks, including the one-cycle done pulse.
    task automatic run_conv(input string tag, input logic [31:0] d, input logic fm);
        start_conv(d, fm);
        check_eq({tag, "_busy_start"}, 32'(busy), 32'd1);
        wait_done(tag, 0);
        check_result(tag, d, fm);
        @(posedge sys_clk);
        #1;
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic        fm;
        int          pulses;

        sys_rst_n  = 1'b0;
        start      = 1'b0;
        data_in    = '0;
        field_mode = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_bcd",  bcd_out, 32'd0);
        check_eq("rst_mask", 32'(blank_mask), 32'd0);
        check_eq("rst_ovf",  32'(ovf), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Directed corner cases, with literal expectations for the key ones.
        run_conv("zero_fm0", 32'd0, 1'b0);
        check_eq("zero_fm0_lit", 32'(blank_mask), 32'hFE);
        run_conv("zero_fm1", 32'd0, 1'b1);
        check_eq("zero_fm1_lit", 32'(blank_mask), 32'hEE);
        run_conv("full8", 32'd12345678, 1'b0);
        check_eq("full8_lit", bcd_out, 32'h12345678);
        run_conv("fields_fm1", 32'd120034, 1'b1);
        check_eq("fields_fm1_lit", 32'(blank_mask), 32'hCC);
        run_conv("fields_fm0", 32'd120034, 1'b0);
        check_eq("fields_fm0_lit", 32'(blank_mask), 32'hC0);
        run_conv("max", 32'd99999999, 1'b0);
        check_eq("max_lit", bcd_out, 32'h99999999);
        run_conv("ovf_min", 32'd100000000, 1'b0);
        check_eq("ovf_min_lit", bcd_out, 32'hFFFFFFFF);
        run_conv("ovf_max", 32'hFFFF_FFFF, 1'b1);

        // Start during a conversion is ignored.
        start_conv(32'd5678, 1'b0);
        repeat (9) @(posedge sys_clk);
        @(negedge sys_clk);
        start   = 1'b1;
        data_in = 32'd1111;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        wait_done("ignore", 10);
        check_eq("ignore_bcd", bcd_out, 32'h00005678);

        // Back-to-back: start held during the done cycle is taken at the next edge.
        @(negedge sys_clk);
        start_conv(32'd4321, 1'b1);
        wait_done("b2b_first", 0);
        start      = 1'b1;
        data_in    = 32'd87654321;
        field_mode = 1'b0;
        @(posedge sys_clk);
        #1;
        start   = 1'b0;
        data_in = $urandom;
        check_eq("b2b_accept", 32'(busy), 32'd1);
        wait_done("b2b_second", 0);
        check_result("b2b_second", 32'd87654321, 1'b0);

        // Asynchronous reset mid-conversion discards it.
        start_conv(32'd24681357, 1'b0);
        repeat (15) @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_bcd",  bcd_out, 32'd0);
        check_eq("arst_mask", 32'(blank_mask), 32'd0);
        check_eq("arst_ovf",  32'(ovf), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        pulses = 0;
        repeat (50) begin
            @(posedge sys_clk);
            #1;
            if (done || busy) pulses++;
        end
        check_eq("arst_no_done", 32'(pulses), 32'd0);

        // Random words across small, in-range and overflow values.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0:       d = 32'($urandom_range(0, 9999));
                1:       d = (32'($urandom_range(0, 9999)) * 10000) + 32'($urandom_range(0, 9999));
                2:       d = 32'($urandom_range(0, 99999999));
                default: d = $urandom;
            endcase
            fm = 1'($urandom_range(0, 1));
            run_conv("rand", d, fm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_display.md
Name: bin2bcd_display

Overview:
- Consumer-side counterpart of the display data packer. Packed 32-bit binary display words have the form a*10000+b, or a raw setting value.
- Converts one word into 8 BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Also produces a per-digit leading-zero blank mask and an overflow flag.
- Sits between the display-data register and the 8-digit 7-segment scan driver.

Parameters:
- IN_W, 32, input word width; also the number of shift iterations.
- DIGITS, 8, number of BCD output digits; fixed at 8 for the 8-digit display.
- MAX_VAL, 99999999, largest value that can be represented; larger inputs flag overflow.

Ports:
- sys_clk  input  1  system clock; single clock domain.
- sys_rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- data_in  input  32  binary value to convert; latched when start is accepted.
- field_mode  input  1  latched with start. 0 = one 8-digit number; 1 = two independent 4-digit fields (digits 7..4 and 3..0).
- busy  output  1  high while a conversion is in progress (state != IDLE).
- done  output  1  one-cycle pulse when bcd_out, blank_mask and ovf update.
- bcd_out  output  32  8 BCD nibbles; [31:28] = digit 7 (most significant), [3:0] = digit 0.
- blank_mask  output  8  bit i = 1 means digit i is a leading zero and must be blanked.
- ovf  output  1  latched input exceeded MAX_VAL.

Behaviour:
- Reset (async, any state, including mid-conversion): state=IDLE, busy=0, done=0, bcd_out=0, blank_mask=0, ovf=0, internal shift registers and counter cleared. Any in-progress conversion is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE: at an edge with start=1, latch data_in into the shift register and latch field_mode. Compute the overflow flag (data_in > MAX_VAL). Clear the BCD accumulator, set iteration counter=0, go to SHIFT. start=0 stays in IDLE.
- SHIFT: one iteration per clock.
  - Every BCD nibble >= 5 gets +3.
  - Then shift {bcd_acc, bin_reg} left by 1.
  - After iteration IN_W (counter = IN_W-1), go to DONE.
- DONE, one cycle:
  - Register bcd_out from the accumulator, or 32'hFFFFFFFF if overflow.
  - Register blank_mask (all 0 if overflow) and ovf.
  - Pulse done=1 for this cycle only; go to IDLE.
- Latency: start accepted at edge E0. Iterations occur at E1..E32; outputs and done=1 are valid after E33. busy=1 from after E0 until after E33.
  - Overflow inputs take the same 33-cycle latency.
- Back-to-back: start held high from the cycle done is high is accepted at the next edge; the minimum period is 34 cycles.
- start while busy (SHIFT or DONE): ignored, not queued. Changes to data_in and field_mode during a conversion have no effect.
- Outputs hold the last result between conversions.
- blank_mask, field_mode=0: bits 7..1 set for each digit, from digit 7 downward, while that digit and all more-significant digits are 0. Bit 0 is always 0.
- blank_mask, field_mode=1: the same rule applied separately within digits 7..4 and within digits 3..0. Bits 4 and 0 are always 0.
- The blank mask is computed combinationally from the final accumulator and registered in DONE.
- All arithmetic is unsigned. The accumulator is 4*DIGITS bits. Carries out of digit 7 are discarded; overflow inputs are covered by ovf.

Test Plan:
- Reset, then start with data_in=0, field_mode=0 -> after E33: bcd_out=0x00000000, blank_mask=0xFE, ovf=0, done high exactly 1 cycle. Same input with field_mode=1 -> blank_mask=0xEE.
- data_in=12345678 (0x00BC614E) -> bcd_out=0x12345678, blank_mask=0x00, ovf=0. Check busy high for exactly 33 cycles and done exactly 33 edges after acceptance.
- data_in=120034 (12*10000+34), field_mode=1 -> bcd_out=0x00120034, blank_mask=0xCC. Same input with field_mode=0 -> blank_mask=0xC0.
- data_in=99999999 -> bcd_out=0x99999999, ovf=0. Then data_in=100000000 -> bcd_out=0xFFFFFFFF, blank_mask=0x00, ovf=1, same latency.
- Start with 5678. Pulse start again at cycle 10 with data_in=1111 -> ignored; result 0x00005678. Hold start high during done -> next conversion accepted at the following edge.
- Assert sys_rst_n=0 asynchronously at iteration 15 of a conversion -> all outputs 0 immediately. After release, no done pulse occurs until a new start.
